// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle controller and its datapath.
// master = controller side, slave = datapath side.
interface multicycle_ctrl_if;
   logic [19:0] Instr;
   logic [3:0]  ALUFlags;
   logic        PCWrite;
   logic        AdrSrc;
   logic        MemWrite;
   logic        IRWrite;
   logic        RegWrite;
   logic [1:0]  ResultSrc;
   logic        ALUSrcA;
   logic [1:0]  ALUSrcB;
   logic [1:0]  ALUControl;
   logic [1:0]  ImmSrc;
   logic [1:0]  RegSrc;
   logic [3:0]  State;

   modport master (
      input  Instr, ALUFlags,
      output PCWrite, AdrSrc, MemWrite, IRWrite,
      output RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
      output ALUControl, ImmSrc, RegSrc, State
   );

   modport slave (
      output Instr, ALUFlags,
      input  PCWrite, AdrSrc, MemWrite, IRWrite,
      input  RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
      input  ALUControl, ImmSrc, RegSrc, State
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore FSM control unit for a multicycle ARMv4-subset datapath,
// with ALU decode, NZCV flag register and condition evaluation.
module multicycle_ctrl #(
   parameter logic [3:0] FLAGS_RESET  = 4'b0000,
   parameter bit         UNDEF_AS_NOP = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   multicycle_ctrl_if.master  bus
);

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      EXECR   = 4'd6,
      EXECI   = 4'd7,
      ALUWB   = 4'd8,
      BRANCH  = 4'd9,
      UNKNOWN = 4'd15
   } state_e;

   state_e      state_q, state_d, out_st;
   logic [3:0]  flags_q, flags_d;
   logic        cond_q, cond_d;

   logic [3:0]  cond;
   logic [1:0]  op;
   logic [5:0]  funct;
   logic [3:0]  rd;
   logic        unused_rn;

   assign cond      = bus.Instr[19:16];
   assign op        = bus.Instr[15:14];
   assign funct     = bus.Instr[13:8];
   assign rd        = bus.Instr[3:0];
   assign unused_rn = ^bus.Instr[7:4];

   logic n, z, c, v;
   logic cond_ex;

   assign {n, z, c, v} = flags_q;

   always_comb begin
      cond_ex = 1'b0;
      unique case (cond)
         4'h0:    cond_ex = z;
         4'h1:    cond_ex = ~z;
         4'h2:    cond_ex = c;
         4'h3:    cond_ex = ~c;
         4'h4:    cond_ex = n;
         4'h5:    cond_ex = ~n;
         4'h6:    cond_ex = v;
         4'h7:    cond_ex = ~v;
         4'h8:    cond_ex = c & ~z;
         4'h9:    cond_ex = ~c | z;
         4'ha:    cond_ex = (n == v);
         4'hb:    cond_ex = (n != v);
         4'hc:    cond_ex = ~z & (n == v);
         4'hd:    cond_ex = z | (n != v);
         4'he:    cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end

   // Unsupported DP commands fall back to ADD but never touch flags.
   logic [1:0] dp_ctrl;
   logic       dp_known;
   logic       dp_arith;

   always_comb begin
      dp_ctrl  = 2'b00;
      dp_known = 1'b1;
      dp_arith = 1'b0;
      unique case (funct[4:1])
         4'b0100: dp_arith = 1'b1;
         4'b0010: begin
            dp_ctrl  = 2'b01;
            dp_arith = 1'b1;
         end
         4'b0000: dp_ctrl  = 2'b10;
         4'b1100: dp_ctrl  = 2'b11;
         default: dp_known = 1'b0;
      endcase
   end

   logic is_exec;
   logic flag_we;

   assign is_exec = (state_q == EXECR) || (state_q == EXECI);
   assign flag_we = is_exec & funct[0] & cond_q & dp_known;

   always_comb begin
      flags_d = flags_q;
      if (flag_we) begin
         flags_d[3:2] = bus.ALUFlags[3:2];
         if (dp_arith) flags_d[1:0] = bus.ALUFlags[1:0];
      end
   end

   assign cond_d = (state_q == DECODE) ? cond_ex : cond_q;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         FETCH:  state_d = DECODE;
         DECODE: begin
            unique case (op)
               2'b00:   state_d = funct[5] ? EXECI : EXECR;
               2'b01:   state_d = MEMADR;
               2'b10:   state_d = BRANCH;
               default: state_d = UNDEF_AS_NOP ? FETCH : UNKNOWN;
            endcase
         end
         MEMADR: state_d = funct[0] ? MEMRD : MEMWR;
         MEMRD:  state_d = MEMWB;
         EXECR:  state_d = ALUWB;
         EXECI:  state_d = ALUWB;
         MEMWB:  state_d = FETCH;
         MEMWR:  state_d = FETCH;
         ALUWB:  state_d = FETCH;
         BRANCH: state_d = FETCH;
         default: state_d = UNKNOWN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FETCH;
         flags_q <= FLAGS_RESET;
         cond_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         flags_q <= flags_d;
         cond_q  <= cond_d;
      end
   end

   // While reset is high, present FETCH with every enable held low.
   assign out_st = reset ? FETCH : state_q;

   always_comb begin
      bus.PCWrite    = 1'b0;
      bus.AdrSrc     = 1'b0;
      bus.MemWrite   = 1'b0;
      bus.IRWrite    = 1'b0;
      bus.RegWrite   = 1'b0;
      bus.ResultSrc  = 2'b00;
      bus.ALUSrcA    = 1'b0;
      bus.ALUSrcB    = 2'b00;
      bus.ALUControl = 2'b00;
      bus.ImmSrc     = op;
      bus.RegSrc     = {op == 2'b01, op == 2'b10};
      bus.State      = out_st;
      unique case (out_st)
         FETCH: begin
            bus.IRWrite   = 1'b1;
            bus.PCWrite   = 1'b1;
            bus.ALUSrcA   = 1'b1;
            bus.ALUSrcB   = 2'b10;
            bus.ResultSrc = 2'b10;
         end
         DECODE: begin
            bus.ALUSrcA   = 1'b1;
            bus.ALUSrcB   = 2'b10;
            bus.ResultSrc = 2'b10;
         end
         MEMADR: bus.ALUSrcB = 2'b01;
         MEMRD:  bus.AdrSrc  = 1'b1;
         MEMWR: begin
            bus.AdrSrc   = 1'b1;
            bus.MemWrite = cond_q;
         end
         MEMWB: begin
            bus.ResultSrc = 2'b01;
            bus.RegWrite  = cond_q;
            bus.PCWrite   = cond_q & (rd == 4'd15);
         end
         EXECR: bus.ALUControl = dp_ctrl;
         EXECI: begin
            bus.ALUSrcB    = 2'b01;
            bus.ALUControl = dp_ctrl;
         end
         ALUWB: begin
            bus.RegWrite = cond_q;
            bus.PCWrite  = cond_q & (rd == 4'd15);
         end
         BRANCH: begin
            bus.ALUSrcB   = 2'b01;
            bus.ResultSrc = 2'b10;
            bus.PCWrite   = cond_q;
         end
         default: ;
      endcase
      if (reset) begin
         bus.PCWrite  = 1'b0;
         bus.IRWrite  = 1'b0;
         bus.RegWrite = 1'b0;
         bus.MemWrite = 1'b0;
      end
   end

endmodule
